// File: rtl/add_scheduler.sv
// add_scheduler: shares one self-timed ripple adder chain among NREQ clocked
// requesters. Round-robin arbitration, four-phase req/fin handshake with a
// synchronised all-done flag, timeout recovery, one-cycle ack with result.
//
// state  | meaning
// IDLE   | no operation; arbitrate among pending req_i
// LOAD   | operands driven to chain, add_req_o still low
// RUN    | add_req_o high, waiting for synchronised all-done
// RTZ    | add_req_o low, waiting for all-done to return to zero
// DONE   | ack_o pulse with result; advance round-robin pointer
module add_scheduler #(
  parameter int W           = 8,
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] a_i,
  input  logic [NREQ*W-1:0] b_i,
  input  logic [NREQ-1:0]   cin_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              ack_o,
  output logic [W-1:0]      sum_o,
  output logic              cout_o,
  output logic              err_o,
  output logic              add_req_o,
  output logic [W-1:0]      add_x_o,
  output logic [W-1:0]      add_y_o,
  output logic              add_cin_o,
  input  logic [W-1:0]      add_fin_i,
  input  logic [W-1:0]      add_s_i,
  input  logic              add_cout_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam int ST_RUN_BIT  = 2;
  localparam int ST_DONE_BIT = 4;

  // One-hot so add_req_o comes straight off a flop and cannot glitch into
  // the self-timed chain.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_RUN  = 5'b00100,
    S_RTZ  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_done_raw;
  logic                   w_done_s;
  logic [IW-1:0]          r_rr;
  logic [IW-1:0]          r_win;
  logic [IW-1:0]          w_win;
  logic                   w_found;
  logic [7:0]             r_cnt;
  logic                   w_tmo;
  logic [NREQ-1:0]        r_gnt;
  logic [W-1:0]           r_sum;
  logic                   r_cout;
  logic                   r_err;
  logic [W-1:0]           r_x;
  logic [W-1:0]           r_y;
  logic                   r_cin;

  assign w_done_raw = &add_fin_i;
  assign w_done_s   = r_sync[SYNC_STAGES-1];
  assign w_tmo      = (r_cnt == TO_LAST);

  // Bring the asynchronous all-done level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], w_done_raw};
  end

  // Round-robin pick: first set request at or above r_rr, wrapping.
  always_comb begin
    int v_idx;
    w_win   = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = int'(r_rr) + i;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && req_i[v_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[IW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; completion has priority over timeout in RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_done_s || w_tmo) w_next = S_RTZ;
      S_RTZ:   if (!w_done_s || w_tmo) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from single state bits.
  always_comb begin
    add_req_o = r_state[ST_RUN_BIT];
    ack_o     = r_state[ST_DONE_BIT];
  end

  // Phase timer: restarts on every state change, counts in RUN and RTZ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_cnt <= '0;
    else if (w_next != r_state)               r_cnt <= '0;
    else if (r_state == S_RUN || r_state == S_RTZ) r_cnt <= r_cnt + 8'd1;
  end

  // Grant, operand, result and round-robin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= '0;
      r_win  <= '0;
      r_rr   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_cin  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          // Latch on LOAD entry so operands lead add_req_o by a full cycle.
          r_win  <= w_win;
          r_gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          r_x    <= a_i[int'(w_win)*W +: W];
          r_y    <= b_i[int'(w_win)*W +: W];
          r_cin  <= cin_i[w_win];
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_err  <= 1'b0;
        end
        S_RUN: begin
          if (w_done_s) begin
            r_sum  <= add_s_i;
            r_cout <= add_cout_i;
          end else if (w_tmo) begin
            r_err  <= 1'b1;
            r_sum  <= '0;
            r_cout <= 1'b0;
          end
        end
        S_RTZ: if (w_done_s && w_tmo) r_err <= 1'b1;
        S_DONE: begin
          r_gnt <= '0;
          r_rr  <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign sum_o     = r_sum;
  assign cout_o    = r_cout;
  assign err_o     = r_err;
  assign add_x_o   = r_x;
  assign add_y_o   = r_y;
  assign add_cin_o = r_cin;

endmodule

// File: tb/tb_add_scheduler.sv
// Bench for add_scheduler: behavioural adder chain with programmable
// completion delay / stuck modes, directed vector table plus corner sequences.
module tb_add_scheduler;

  localparam int W       = 8;
  localparam int NREQ    = 4;
  localparam int SYNC    = 2;
  localparam int TMO     = 255;
  localparam int FIN_DLY = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req_i = '0;
  logic [NREQ*W-1:0] a_i = '0;
  logic [NREQ*W-1:0] b_i = '0;
  logic [NREQ-1:0]  cin_i = '0;
  logic [NREQ-1:0]  gnt_o;
  logic             ack_o;
  logic [W-1:0]     sum_o;
  logic             cout_o;
  logic             err_o;
  logic             add_req_o;
  logic [W-1:0]     add_x_o;
  logic [W-1:0]     add_y_o;
  logic             add_cin_o;
  logic [W-1:0]     add_fin_i;
  logic [W-1:0]     add_s_i;
  logic             add_cout_i;

  add_scheduler #(.W(W), .NREQ(NREQ), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .sum_o(sum_o), .cout_o(cout_o), .err_o(err_o),
    .add_req_o(add_req_o), .add_x_o(add_x_o), .add_y_o(add_y_o), .add_cin_o(add_cin_o),
    .add_fin_i(add_fin_i), .add_s_i(add_s_i), .add_cout_i(add_cout_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int chain_mode = 0;   // 0 normal, 1 fin stuck at 0, 2 fin never returns to 0
  int req_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ack pulse counter, sampled well after the active edge.
  initial forever begin
    @(posedge clk); #2;
    if (ack_o === 1'b1) ack_cnt++;
  end

  // Behavioural chain: zero-operand bits finish at once, the rest after FIN_DLY
  // cycles of add_req_o; sum bits are inverted until every stage is done.
  initial begin
    logic [W:0] full;
    add_fin_i  = '0;
    add_s_i    = '0;
    add_cout_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (add_req_o) begin
        if (req_age < 1000) req_age++;
      end else begin
        req_age = 0;
      end
      if (chain_mode == 1)        add_fin_i = '0;
      else if (add_req_o)         add_fin_i = (req_age >= FIN_DLY) ? '1 : ~(add_x_o | add_y_o);
      else if (chain_mode != 2)   add_fin_i = '0;
      full = {1'b0, add_x_o} + {1'b0, add_y_o} + {{W{1'b0}}, add_cin_o};
      if (&add_fin_i) {add_cout_i, add_s_i} = full;
      else            {add_cout_i, add_s_i} = ~full;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input string tag, input logic [3:0] req,
                       input logic [31:0] a_all, input logic [31:0] b_all,
                       input logic [3:0] c_all, input int win,
                       input logic [7:0] e_sum, input logic e_cout, input logic e_err,
                       input bit hold, output int t_rise, output int t_fall, output int t_ack);
    int k;
    logic [7:0] ex, ey;
    logic ec;
    ex = a_all[win*8 +: 8];
    ey = b_all[win*8 +: 8];
    ec = c_all[win];
    @(negedge clk);
    req_i = req; a_i = a_all; b_i = b_all; cin_i = c_all;
    k = 0;
    while (gnt_o == '0 && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_gnt_load"}, 32'(gnt_o), 32'(1) << win);
    chk({tag, "_req_in_load"}, 32'(add_req_o), 32'd0);
    chk({tag, "_x_load"}, 32'(add_x_o), 32'(ex));
    chk({tag, "_y_load"}, 32'(add_y_o), 32'(ey));
    chk({tag, "_cin_load"}, 32'(add_cin_o), 32'(ec));
    k = 0;
    while (!add_req_o && k < 5) begin @(negedge clk); k++; end
    t_rise = cyc;
    chk({tag, "_req_rise"}, 32'(add_req_o), 32'd1);
    chk({tag, "_x_run"}, 32'(add_x_o), 32'(ex));
    k = 0;
    while (add_req_o && k < 600) begin @(negedge clk); k++; end
    t_fall = cyc;
    k = 0;
    while (!ack_o && k < 600) begin @(negedge clk); k++; end
    t_ack = cyc;
    chk({tag, "_ack"}, 32'(ack_o), 32'd1);
    chk({tag, "_sum"}, 32'(sum_o), 32'(e_sum));
    chk({tag, "_cout"}, 32'(cout_o), 32'(e_cout));
    chk({tag, "_err"}, 32'(err_o), 32'(e_err));
    chk({tag, "_gnt_done"}, 32'(gnt_o), 32'(1) << win);
    chk({tag, "_rtz_before_ack"}, 32'(t_fall < t_ack), 32'd1);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(ack_o), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt_o), 32'd0);
    if (!hold) req_i = '0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         win;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int tr, tf, ta, a0, k;
    logic [31:0] aa, bb;
    logic [3:0]  cc;

    // round-robin pointer is 0 when the table starts
    vecs[0] = '{4'b0001, 8'h5A, 8'hA5, 1'b0, 0, 8'hFF, 1'b0};
    vecs[1] = '{4'b0001, 8'hFF, 8'h01, 1'b1, 0, 8'h01, 1'b1};
    vecs[2] = '{4'b1001, 8'h80, 8'h80, 1'b0, 3, 8'h00, 1'b1};
    vecs[3] = '{4'b1001, 8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0};
    vecs[4] = '{4'b0110, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0};
    vecs[5] = '{4'b0110, 8'hFF, 8'hFF, 1'b1, 2, 8'hFF, 1'b1};
    vecs[6] = '{4'b0011, 8'h0F, 8'hF0, 1'b0, 0, 8'hFF, 1'b0};
    vecs[7] = '{4'b1000, 8'h12, 8'h34, 1'b1, 3, 8'h47, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_add_req", 32'(add_req_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_x", 32'(add_x_o), 32'd0);
    rst_n = 1'b1;

    // all four requesting continuously: strict rotation from requester 0
    a0 = ack_cnt;
    for (int i = 0; i < 8; i++)
      do_op($sformatf("rr%0d", i), 4'b1111, {4{8'h21}}, {4{8'h10}}, 4'b0000,
            i % 4, 8'h31, 1'b0, 1'b0, (i != 7), tr, tf, ta);
    chk("rr_ack_count", 32'(ack_cnt - a0), 32'd8);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      aa = '0; bb = '0; cc = '0;
      aa[vecs[i].win*8 +: 8] = vecs[i].a;
      bb[vecs[i].win*8 +: 8] = vecs[i].b;
      cc[vecs[i].win]        = vecs[i].cin;
      do_op($sformatf("v%0d", i), vecs[i].req, aa, bb, cc, vecs[i].win,
            vecs[i].sum, vecs[i].cout, 1'b0, 1'b0, tr, tf, ta);
    end

    // completion never arrives: timeout in RUN
    chain_mode = 1;
    do_op("tmo_run", 4'b0001, 32'h0000_0033, 32'h0000_0011, 4'b0000, 0,
          8'h00, 1'b0, 1'b1, 1'b0, tr, tf, ta);
    chk("tmo_run_latency", 32'(ta - tr), 32'(TMO + 1));
    chain_mode = 0;
    do_op("after_run_tmo", 4'b0010, 32'h0000_0100, 32'h0000_0100, 4'b0000, 1,
          8'h02, 1'b0, 1'b0, 1'b0, tr, tf, ta);

    // completion never returns to zero: timeout in RTZ
    chain_mode = 2;
    do_op("tmo_rtz", 4'b0100, 32'h0010_0000, 32'h0020_0000, 4'b0000, 2,
          8'h30, 1'b0, 1'b1, 1'b0, tr, tf, ta);
    chk("tmo_rtz_latency", 32'(ta - tf), 32'(TMO));
    chain_mode = 0;
    repeat (4) @(negedge clk);
    do_op("after_rtz_tmo", 4'b0100, 32'h0005_0000, 32'h0006_0000, 4'b0000, 2,
          8'h0B, 1'b0, 1'b0, 1'b0, tr, tf, ta);

    // reset during RUN; round-robin pointer was 3 beforehand
    @(negedge clk);
    req_i = 4'b0100; a_i = 32'h0033_0000; b_i = 32'h0044_0000; cin_i = '0;
    k = 0;
    while (!add_req_o && k < 20) begin @(negedge clk); k++; end
    chk("mid_rst_run", 32'(add_req_o), 32'd1);
    @(negedge clk);
    a0 = ack_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_add_req", 32'(add_req_o), 32'd0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
    chk("mid_rst_ack", 32'(ack_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    req_i = 4'b1100; a_i = 32'hF033_0000; b_i = 32'h0F44_0000;
    chk("mid_rst_no_ack", 32'(ack_cnt - a0), 32'd0);
    do_op("post_rst", 4'b1100, 32'hF033_0000, 32'h0F44_0000, 4'b0000, 2,
          8'h77, 1'b0, 1'b0, 1'b0, tr, tf, ta);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_scheduler.md
Name: add_scheduler

Overview:
- Clocked controller that shares one W-bit ripple full-adder chain among NREQ requesters.
- Each full-adder stage raises its completion flag when it is done; the block detects that per-bit completion, with early finish on bits where x=y=0.
- Sequences the chain with a four-phase req/fin protocol: launch, wait for all-done, return-to-zero.
- Arbitrates round-robin between requesters, then returns sum/carry to the winner with a one-cycle ack.
- Sits between the clocked issue logic and the self-timed arithmetic datapath.

Parameters:
- W, 8, operand width; equals the number of full-adder stages in the chain.
- NREQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flops in the completion synchroniser (2..3).
- TIMEOUT, 255, max cycles in RUN or RTZ before error; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester request level; held until that requester's ack
- a_i  in  NREQ*W  operand x; requester k occupies bits [k*W +: W]
- b_i  in  NREQ*W  operand y; same packing as a_i
- cin_i  in  NREQ  carry-in per requester
- gnt_o  out  NREQ  one-hot grant; held from LOAD through DONE
- ack_o  out  1  one-cycle pulse; sum_o/cout_o/err_o valid in the same cycle
- sum_o  out  W  result
- cout_o  out  1  carry out
- err_o  out  1  timeout flag; qualified by ack_o
- add_req_o  out  1  chain request; drives both reqParent and req of every stage
- add_x_o  out  W  registered operand x to the chain
- add_y_o  out  W  registered operand y to the chain
- add_cin_o  out  1  registered carry-in to the chain
- add_fin_i  in  W  per-stage completion flags; asynchronous to clk
- add_s_i  in  W  chain sum bits
- add_cout_i  in  1  chain carry out of the top stage

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0, timeout counter=0, synchroniser flops=0;
  - all outputs 0.
- rst_n deasserts synchronously to clk at integration level.
- Completion:
  - done_raw = AND-reduce of add_fin_i;
  - done_s = done_raw after SYNC_STAGES flops;
  - only done_s is used by the FSM.
- IDLE:
  - if any req_i is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NREQ;
  - set gnt_o one-hot, go to LOAD.
- LOAD (1 cycle):
  - latch the winner's a/b/cin into add_x_o/add_y_o/add_cin_o;
  - add_req_o stays 0; go to RUN next cycle.
  - Operands are therefore stable at least one cycle before add_req_o rises.
- RUN:
  - add_req_o=1; counter increments every cycle.
  - When done_s=1: capture add_s_i into sum_o and add_cout_i into cout_o (the chain is settled once every fin is high); go to RTZ.
  - If the counter reaches TIMEOUT first: set err_o, set sum_o=0 and cout_o=0, go to RTZ.
- RTZ:
  - add_req_o=0; counter restarts from 0.
  - Wait for done_s=0, then go to DONE.
  - On timeout here: set err_o and go to DONE anyway.
- DONE (1 cycle):
  - ack_o=1; clear gnt_o; rr_ptr = winner+1 mod NREQ; go to IDLE.
  - The next grant cannot occur before the cycle after DONE, so minimum spacing between acks is 5 + 2*SYNC_STAGES cycles.
- Requester rules:
  - A requester drops req_i in the cycle after ack_o; if it still has req_i high then, that is a new request.
  - A winner dropping req_i before ack does not abort the operation; the result is still produced and acked.
- Simultaneous requests are resolved by rr_ptr only. Fairness: no requester waits more than NREQ-1 operations.
- Arithmetic:
  - {cout_o, sum_o} = a + b + cin, modulo 2^(W+1).
  - Early-finish bits (x=y=0) do not change the result, only completion time.
- Latency: sum_o is not sampled before done_s in any state.
- Reset mid-operation: all outputs drop immediately, including add_req_o, so the chain returns to zero; no ack is issued for the in-flight request.
- err_o and cout_o/sum_o hold their values until the next LOAD and are qualified only by ack_o.

Test Plan:
1. W=8, req_i=0001, a=8'h5A, b=8'hA5, cin=0; add_fin_i goes high 3 cycles after add_req_o -> ack_o once, sum_o=8'hFF, cout_o=0, err_o=0, add_req_o back to 0 before ack_o.
2. req_i=0001, a=8'hFF, b=8'h01, cin=1 -> sum_o=8'h01, cout_o=1; add_x_o/add_y_o stable in the cycle before add_req_o rises.
3. req_i=1111 held for 8 operations from reset -> grant order 0,1,2,3,0,1,2,3; each gnt_o one-hot; exactly 8 ack pulses.
4. add_fin_i stuck at 0 during RUN -> ack_o and err_o asserted at RUN entry + TIMEOUT cycles + RTZ exit + 1; sum_o=0; the next request is then serviced normally.
5. add_fin_i stuck at 1 after add_req_o falls (RTZ never completes) -> err_o asserted with ack after the TIMEOUT count in RTZ; FSM returns to IDLE.
6. rst_n pulsed low during RUN with req_i=0100 -> add_req_o and gnt_o drop immediately, no ack_o, rr_ptr=0; after release, requester 2 is re-granted and acked normally.
